// File: rtl/tdm_demux2.sv
// tdm_demux2: receive side of a two-channel serial TDM link.
// Ports: clk/rst (sync, active-high); din/dvalid/fsync serial input;
//   a_out/a_vld, b_out/b_vld recovered words; sel marks slot A;
//   sync_err pulses on a frame marker seen mid-frame.
module tdm_demux2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         din,
    input  logic         dvalid,
    input  logic         fsync,
    output logic [W-1:0] a_out,
    output logic         a_vld,
    output logic [W-1:0] b_out,
    output logic         b_vld,
    output logic         sel,
    output logic         sync_err
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SLOT_A,
        SLOT_B
    } state_t;

    state_t        state, state_n;
    logic [W-1:0]  sh, sh_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0]  a_n, b_n;
    logic          av_n, bv_n, err_n;
    logic [W-1:0]  shifted;

    assign shifted = {sh[W-2:0], din};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            a_out    <= '0;
            b_out    <= '0;
            a_vld    <= 1'b0;
            b_vld    <= 1'b0;
            sync_err <= 1'b0;
            sel      <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            cnt      <= cnt_n;
            a_out    <= a_n;
            b_out    <= b_n;
            a_vld    <= av_n;
            b_vld    <= bv_n;
            sync_err <= err_n;
            sel      <= (state_n == SLOT_A);
        end
    end

    always_comb begin
        state_n = state;
        sh_n    = sh;
        cnt_n   = cnt;
        a_n     = a_out;
        b_n     = b_out;
        av_n    = 1'b0;
        bv_n    = 1'b0;
        err_n   = 1'b0;
        if (dvalid) begin
            if (fsync) begin
                // A marker always starts a fresh A slot; inside a
                // frame it also drops the partial word.
                err_n   = (state != IDLE);
                sh_n    = {{(W-1){1'b0}}, din};
                cnt_n   = CW'(1);
                state_n = SLOT_A;
            end else begin
                case (state)
                    SLOT_A, SLOT_B: begin
                        sh_n = shifted;
                        if (cnt == LAST) begin
                            cnt_n = '0;
                            if (state == SLOT_A) begin
                                a_n     = shifted;
                                av_n    = 1'b1;
                                state_n = SLOT_B;
                            end else begin
                                b_n     = shifted;
                                bv_n    = 1'b1;
                                state_n = IDLE;
                            end
                        end else begin
                            cnt_n = cnt + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux2.sv
// tb_tdm_demux2: randomized scoreboard bench for tdm_demux2.
// A frame-level bit-list model predicts pulses, words and sel.
module tb_tdm_demux2;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, din, dvalid, fsync;
    logic [W-1:0] a_out, b_out;
    logic         a_vld, b_vld, sel, sync_err;

    tdm_demux2 #(.W(W)) dut (
        .clk(clk), .rst(rst), .din(din), .dvalid(dvalid),
        .fsync(fsync), .a_out(a_out), .a_vld(a_vld),
        .b_out(b_out), .b_vld(b_vld), .sel(sel),
        .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    // kind is the expected {a_vld, b_vld, sync_err} pattern
    typedef struct {
        logic [2:0]   kind;
        logic [W-1:0] val;
    } ev_t;

    ev_t          sbq[$];
    int           checks = 0;
    int           errors = 0;
    bit           mon_en = 0;

    // reference model: bits received so far in the current frame
    bit           bits[$];
    bit           in_frame = 0;
    logic [W-1:0] exp_a = '0, exp_b = '0;
    logic         exp_sel = 1'b0;

    function automatic logic [W-1:0] pack(int from);
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++) v = {v[W-2:0], bits[from + i]};
        return v;
    endfunction

    task automatic model_sample(bit d, bit f);
        ev_t e;
        if (f) begin
            if (in_frame) begin
                e.kind = 3'b001; e.val = '0; sbq.push_back(e);
            end
            bits.delete();
            bits.push_back(d);
            in_frame = 1;
        end else if (in_frame) begin
            bits.push_back(d);
            if (bits.size() == W) begin
                exp_a = pack(0);
                e.kind = 3'b100; e.val = exp_a; sbq.push_back(e);
            end else if (bits.size() == 2 * W) begin
                exp_b = pack(W);
                e.kind = 3'b010; e.val = exp_b; sbq.push_back(e);
                in_frame = 0;
                bits.delete();
            end
        end
        exp_sel = in_frame && (bits.size() < W);
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (mon_en) begin
            e.kind = 3'b000; e.val = '0;
            if (sbq.size() > 0) e = sbq.pop_front();
            checks++;
            if ({a_vld, b_vld, sync_err} !== e.kind) begin
                errors++;
                $display("FAIL pulses: got %b want %b at %0t",
                         {a_vld, b_vld, sync_err}, e.kind, $time);
            end
            if (e.kind == 3'b100) begin
                checks++;
                if (a_out !== e.val) begin
                    errors++;
                    $display("FAIL a_word: got %h want %h", a_out, e.val);
                end
            end
            if (e.kind == 3'b010) begin
                checks++;
                if (b_out !== e.val) begin
                    errors++;
                    $display("FAIL b_word: got %h want %h", b_out, e.val);
                end
            end
            checks++;
            if (a_out !== exp_a || b_out !== exp_b) begin
                errors++;
                $display("FAIL hold: got a=%h b=%h want a=%h b=%h at %0t",
                         a_out, b_out, exp_a, exp_b, $time);
            end
            checks++;
            if (sel !== exp_sel) begin
                errors++;
                $display("FAIL sel: got %b want %b at %0t",
                         sel, exp_sel, $time);
            end
        end
    end

    task automatic do_reset(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1; din = 1'($urandom);
            dvalid = 1'($urandom); fsync = 1'($urandom);
            @(posedge clk);
            sbq.delete();
            bits.delete();
            in_frame = 0; exp_a = '0; exp_b = '0; exp_sel = 0;
            mon_en = 1;
        end
        @(negedge clk);
        rst = 0; dvalid = 0; fsync = 0; din = 0;
    endtask

    task automatic send_bit(bit d, bit f, int gap);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            dvalid = 0; din = 1'($urandom); fsync = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        dvalid = 1; din = d; fsync = f;
        @(posedge clk);
        model_sample(d, f);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dvalid = 0; fsync = 1'($urandom); din = 1'($urandom);
            @(posedge clk);
        end
    endtask

    task automatic frame(logic [W-1:0] a, logic [W-1:0] b, int gap,
                         bit rgap);
        for (int i = W - 1; i >= 0; i--)
            send_bit(a[i], i == W - 1, rgap ? $urandom_range(0, 2) : gap);
        for (int i = W - 1; i >= 0; i--)
            send_bit(b[i], 1'b0, rgap ? $urandom_range(0, 2) : gap);
    endtask

    initial begin
        logic [W-1:0] w;
        int           k;
        rst = 1; din = 0; dvalid = 0; fsync = 0;

        do_reset(3);
        idle(1);

        frame(8'hA5, 8'h3C, 0, 0);
        idle(2);
        frame(8'hA5, 8'h3C, 1, 0);
        idle(2);

        w = 8'hF0;
        for (int i = W - 1; i >= W - 4; i--)
            send_bit(w[i], i == W - 1, 0);
        frame(8'h12, 8'h34, 0, 0);
        idle(2);

        for (int i = 0; i < 20; i++) send_bit(1'($urandom), 1'b0, 0);
        frame(8'hFF, 8'h00, 0, 0);
        frame(8'h81, 8'h7E, 0, 0);
        idle(2);

        w = 8'h6B;
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], i == W - 1, 0);
        send_bit(1'b1, 1'b0, 0);
        send_bit(1'b0, 1'b0, 0);
        do_reset(1);
        frame(8'h5A, 8'hC3, 0, 0);
        idle(2);

        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0, 1: frame(W'($urandom), W'($urandom), 0, 1);
                2: begin
                    k = $urandom_range(1, 2 * W - 1);
                    send_bit(1'($urandom), 1'b1, 0);
                    for (int i = 1; i < k; i++)
                        send_bit(1'($urandom), 1'b0, $urandom_range(0, 1));
                end
                default: begin
                    for (int i = 0; i < $urandom_range(1, 6); i++)
                        send_bit(1'($urandom), 1'b0, $urandom_range(0, 1));
                    idle($urandom_range(0, 3));
                end
            endcase
        end
        idle(4);

        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
